uart_tx_buf: RTL and testbench

- Byte-level UART transmitter with a small input FIFO.
- Sits directly downstream of the print/formatter stage: consumes its d_tx/vld_tx byte stream, returns rdy_tx, and drives the serial line to the host.
- Serialises 8N1 frames at a fixed baud derived from the system clock.

---
 rtl/uart_tx_buf_if.sv | 10 +
 rtl/uart_tx_buf.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_buf.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buf_if.sv
// Byte handshake between the upstream formatter and the UART transmitter.
// A byte transfers on any rising clock edge where vld_tx && rdy_tx.
interface uart_tx_buf_if;
   logic       vld_tx;
   logic [7:0] d_tx;
   logic       rdy_tx;

   modport master (output vld_tx, output d_tx, input rdy_tx);
   modport slave  (input vld_tx, input d_tx, output rdy_tx);
endinterface

// File: rtl/uart_tx_buf.sv
// Byte-level 8N1 UART transmitter fed by a small power-of-two FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 frames).
module uart_tx_buf #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600,
   parameter int DEPTH    = 16
) (
   input  logic         clk,
   input  logic         rstn,
   uart_tx_buf_if.slave up,
   output logic         txd,
   output logic         busy
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int BW  = $clog2(DIV);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   state_t        state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic          txd_q;
   logic [7:0]    shift_q;
`ifdef UART_TX_PARITY_EN
   logic          par_q;
`endif

   logic full, empty, push, pop, baud_last;

   // rdy_tx depends only on the occupancy flop, never on vld_tx.
   assign full      = (cnt_q == CW'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign push      = up.vld_tx && !full;
   assign pop       = (state_q == IDLE) && !empty;
   assign baud_last = (baud_q == BW'(DIV - 1));

   assign up.rdy_tx = !full;
   assign txd       = txd_q;
   assign busy      = (state_q != IDLE) || !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage and shift register carry data only, so they have no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= up.d_tx;
      if (pop) begin
         shift_q <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
         par_q   <= ^mem_q[rd_ptr_q];
`endif
      end else if (state_q == DATA && baud_last) begin
         shift_q <= {1'b0, shift_q[7:1]};
      end
   end

   // txd is loaded one state ahead so each bit appears the cycle its state begins.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         txd_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  state_q <= START;
                  baud_q  <= '0;
                  bit_q   <= '0;
                  txd_q   <= 1'b0;
               end
            end
            START: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  state_q <= DATA;
                  txd_q   <= shift_q[0];
               end else begin
                  baud_q  <= baud_q + BW'(1);
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= PARITY;
                     txd_q   <= par_q;
`else
                     state_q <= STOP;
                     txd_q   <= 1'b1;
`endif
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     txd_q <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  state_q <= STOP;
                  txd_q   <= 1'b1;
               end else begin
                  baud_q  <= baud_q + BW'(1);
               end
            end
`endif
            STOP: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  state_q <= IDLE;
                  txd_q   <= 1'b1;
               end else begin
                  baud_q  <= baud_q + BW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               txd_q   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf with DIV=10 and DEPTH=4.
module tb_uart_tx_buf;

   localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FLEN = NB * DIV;

   logic clk = 1'b0;
   logic rstn;
   logic txd, busy;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   uart_tx_buf_if bus ();

   uart_tx_buf #(.CLK_FREQ(100), .BAUD(10), .DEPTH(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .up   (bus),
      .txd  (txd),
      .busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [10:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b0, 1'b1, b, 1'b0};
`endif
   endfunction

   // Waits for a start bit, then samples every cycle of one frame.
   task automatic recv_frame(output logic [10:0] fr, output int st, output bit ok, output bit stable);
      int n;
      fr = '0; st = 0; ok = 1'b0; stable = 1'b1; n = 0;
      while (txd !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (txd !== 1'b0) return;
      ok = 1'b1;
      st = cyc;
      for (int k = 0; k < FLEN; k++) begin
         if (k > 0) @(negedge clk);
         if (k % DIV == 0) fr[k / DIV] = txd;
         else if (txd !== fr[k / DIV]) stable = 1'b0;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; bus.vld_tx = 1'b0; bus.d_tx = 8'h00;
      #23;
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
      checks++; if (bus.rdy_tx !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", bus.rdy_tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_byte();
      logic [10:0] fr; int st, c0, bl; bit ok, stb;
      @(negedge clk);
      checks++; if (bus.rdy_tx !== 1'b1) begin errors++; $display("FAIL a5_rdy got=%b exp=1", bus.rdy_tx); end
      bus.vld_tx = 1'b1; bus.d_tx = 8'hA5; c0 = cyc;
      @(negedge clk); bus.vld_tx = 1'b0;
      recv_frame(fr, st, ok, stb);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL a5_start got=timeout exp=start bit"); end
      checks++; if (fr !== exp_frame(8'hA5)) begin errors++; $display("FAIL a5_frame got=%h exp=%h", fr, exp_frame(8'hA5)); end
      checks++; if (stb !== 1'b1) begin errors++; $display("FAIL a5_stable got=%b exp=1", stb); end
      checks++; if (st - c0 !== 2) begin errors++; $display("FAIL a5_latency got=%0d exp=2", st - c0); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a5_busy_end got=%b exp=1", busy); end
      @(negedge clk); bl = cyc;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_low got=%b exp=0", busy); end
      checks++; if (bl - st !== FLEN) begin errors++; $display("FAIL a5_len got=%0d exp=%0d", bl - st, FLEN); end
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL a5_idle_txd got=%b exp=1", txd); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [10:0] f1, f2; int s1, s2; bit o1, o2, b1, b2;
      @(negedge clk); bus.vld_tx = 1'b1; bus.d_tx = 8'h41;
      @(negedge clk); bus.d_tx = 8'h42;
      checks++; if (bus.rdy_tx !== 1'b1) begin errors++; $display("FAIL ab_rdy got=%b exp=1", bus.rdy_tx); end
      @(negedge clk); bus.vld_tx = 1'b0;
      recv_frame(f1, s1, o1, b1);
      recv_frame(f2, s2, o2, b2);
      checks++; if ({o1, o2} !== 2'b11) begin errors++; $display("FAIL ab_start got=%b exp=11", {o1, o2}); end
      checks++; if (f1 !== exp_frame(8'h41)) begin errors++; $display("FAIL ab_frame_A got=%h exp=%h", f1, exp_frame(8'h41)); end
      checks++; if (f2 !== exp_frame(8'h42)) begin errors++; $display("FAIL ab_frame_B got=%h exp=%h", f2, exp_frame(8'h42)); end
      checks++; if ({b1, b2} !== 2'b11) begin errors++; $display("FAIL ab_stable got=%b exp=11", {b1, b2}); end
      checks++; if (s2 - s1 !== FLEN + 1) begin errors++; $display("FAIL ab_gap got=%0d exp=%0d", s2 - s1, FLEN + 1); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_fifo_full();
      logic [10:0] frs [6]; int sts [6]; bit oks [6], stb [6];
      int acc, drop_acc, ret_cyc, last_ref;
      acc = 0; drop_acc = -1; ret_cyc = -1; last_ref = -1;
      fork
         begin
            for (int n = 0; n < 3000 && acc < 6; n++) begin
               @(negedge clk);
               if (bus.rdy_tx) begin
                  if (drop_acc >= 0 && ret_cyc < 0) ret_cyc = cyc;
                  bus.vld_tx = 1'b1; bus.d_tx = 8'(8'h30 + acc);
                  acc++;
               end else begin
                  if (drop_acc < 0) drop_acc = acc;
                  last_ref = cyc;
                  bus.vld_tx = 1'b1; bus.d_tx = 8'(8'h30 + acc);
               end
            end
            @(negedge clk); bus.vld_tx = 1'b0;
         end
         begin
            for (int j = 0; j < 6; j++) recv_frame(frs[j], sts[j], oks[j], stb[j]);
         end
      join
      checks++; if (drop_acc !== 5) begin errors++; $display("FAIL full_drop_after got=%0d exp=5", drop_acc); end
      checks++; if (ret_cyc !== sts[1]) begin errors++; $display("FAIL full_rdy_return got=%0d exp=%0d", ret_cyc, sts[1]); end
      checks++; if (last_ref !== ret_cyc - 1) begin errors++; $display("FAIL full_refused_at_pop got=%0d exp=%0d", last_ref, ret_cyc - 1); end
      checks++; if (acc !== 6) begin errors++; $display("FAIL full_accepted got=%0d exp=6", acc); end
      for (int j = 0; j < 6; j++) begin
         checks++;
         if (oks[j] !== 1'b1 || stb[j] !== 1'b1 || frs[j] !== exp_frame(8'(8'h30 + j)))
            begin errors++; $display("FAIL full_frame%0d got=%h ok=%b stable=%b exp=%h", j, frs[j], oks[j], stb[j], exp_frame(8'(8'h30 + j))); end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame(input logic [7:0] b);
      int n, lows, busys;
      @(negedge clk); bus.vld_tx = 1'b1; bus.d_tx = b;
      @(negedge clk); bus.d_tx = 8'h55;
      @(negedge clk); bus.d_tx = 8'h66;
      @(negedge clk); bus.vld_tx = 1'b0;
      n = 0;
      while (txd !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rst_%h_start got=timeout exp=start bit", b); end
      repeat (35) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_%h_txd got=%b exp=1", b, txd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_%h_busy got=%b exp=0", b, busy); end
      @(negedge clk); rstn = 1'b1;
      lows = 0; busys = 0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
         if (busy !== 1'b0) busys++;
      end
      checks++; if (lows !== 0) begin errors++; $display("FAIL rst_%h_no_frame got=%0d low cycles exp=0", b, lows); end
      checks++; if (busys !== 0) begin errors++; $display("FAIL rst_%h_idle got=%0d busy cycles exp=0", b, busys); end
      checks++; if (bus.rdy_tx !== 1'b1) begin errors++; $display("FAIL rst_%h_rdy got=%b exp=1", b, bus.rdy_tx); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity(input logic [7:0] b, input logic p);
      logic [10:0] fr; int st, bl; bit ok, stb;
      @(negedge clk); bus.vld_tx = 1'b1; bus.d_tx = b;
      @(negedge clk); bus.vld_tx = 1'b0;
      recv_frame(fr, st, ok, stb);
      checks++; if (ok !== 1'b1 || stb !== 1'b1) begin errors++; $display("FAIL par_%h_frame got=ok%b stable%b exp=11", b, ok, stb); end
      checks++; if (fr[9] !== p) begin errors++; $display("FAIL par_%h_bit got=%b exp=%b", b, fr[9], p); end
      checks++; if (fr !== exp_frame(b)) begin errors++; $display("FAIL par_%h_all got=%h exp=%h", b, fr, exp_frame(b)); end
      @(negedge clk); bl = cyc;
      checks++; if (busy !== 1'b0 || bl - st !== 110) begin errors++; $display("FAIL par_%h_len got=%0d busy=%b exp=110", b, bl - st, busy); end
      repeat (3) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_fifo_full();
`ifdef UART_TX_PARITY_EN
      test_parity(8'h07, 1'b1);
      test_parity(8'h03, 1'b0);
`endif
      test_reset_mid_frame(8'hFF);
      test_reset_mid_frame(8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
